// File: rtl/i2c_arb_pkg.sv
// ============================================================================
// Module      : i2c_arb_pkg
// Description : Shared widths and FSM state type for the I2C arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ISSUE       = 3'd1,
        S_AWAIT_START = 3'd2,
        S_AWAIT_END   = 3'd3,
        S_COMPLETE    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_arbiter_rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin pick starting just above last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_request,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_idx;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_winner = '0;
        w_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
            if (i_request[w_idx]) begin
                o_winner = w_idx;
            end
        end
    end

    assign o_valid = |i_request;

endmodule

`default_nettype wire

// File: rtl/i2c_arbiter.sv
// ============================================================================
// Module      : i2c_arbiter
// Description : Round-robin arbiter sharing one I2C controller among requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int REPEAT_SZ     = 6,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_activate,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_read_two,
    input  logic [ADDR_W*NUM_REQ-1:0]     req_address,
    input  logic [BYTE_W*NUM_REQ-1:0]     req_location,
    input  logic [BYTE_W*NUM_REQ-1:0]     req_data,
    input  logic [REPEAT_SZ*NUM_REQ-1:0]  req_repeat,
    output logic [NUM_REQ-1:0]            req_busy,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          rsp_success,
    output logic                          rsp_abort,
    output logic [BYTE_W-1:0]             rsp_data1,
    output logic [BYTE_W-1:0]             rsp_data2,
    output logic                          i2c_activate,
    output logic                          i2c_read,
    output logic                          i2c_read_two,
    output logic [ADDR_W-1:0]             i2c_address,
    output logic [BYTE_W-1:0]             i2c_location,
    output logic [BYTE_W-1:0]             i2c_data,
    output logic [REPEAT_SZ-1:0]          i2c_data_repeat,
    input  logic                          i2c_busy,
    input  logic                          i2c_success,
    input  logic                          i2c_abort,
    input  logic [BYTE_W-1:0]             i2c_data1,
    input  logic [BYTE_W-1:0]             i2c_data2
);

    localparam int                 c_IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                 c_TO_W    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(START_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] c_ONE     = NUM_REQ'(1);

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_owner;
    logic [c_IDX_W-1:0]  r_last_grant;
    logic [c_TO_W-1:0]   r_timer;
    logic                r_sticky_success;
    logic                r_sticky_abort;

    logic [c_IDX_W-1:0]  w_winner;
    logic                w_valid;
    logic                w_success_any;
    logic                w_abort_any;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_picker (
        .i_request    (req_activate),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_valid      (w_valid)
    );

    // Include the current cycle so a result coinciding with busy falling is kept.
    assign w_success_any = r_sticky_success | i2c_success;
    assign w_abort_any   = r_sticky_abort   | i2c_abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_owner          <= '0;
            r_last_grant     <= c_IDX_W'(NUM_REQ - 1);
            r_timer          <= '0;
            r_sticky_success <= 1'b0;
            r_sticky_abort   <= 1'b0;
            req_busy         <= '0;
            req_done         <= '0;
            rsp_success      <= 1'b0;
            rsp_abort        <= 1'b0;
            rsp_data1        <= '0;
            rsp_data2        <= '0;
            i2c_activate     <= 1'b0;
            i2c_read         <= 1'b0;
            i2c_read_two     <= 1'b0;
            i2c_address      <= '0;
            i2c_location     <= '0;
            i2c_data         <= '0;
            i2c_data_repeat  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_owner          <= w_winner;
                        i2c_address      <= req_address[w_winner*ADDR_W +: ADDR_W];
                        i2c_location     <= req_location[w_winner*BYTE_W +: BYTE_W];
                        i2c_data         <= req_data[w_winner*BYTE_W +: BYTE_W];
                        i2c_data_repeat  <= req_repeat[w_winner*REPEAT_SZ +: REPEAT_SZ];
                        i2c_read         <= req_read[w_winner];
                        i2c_read_two     <= req_read_two[w_winner];
                        req_busy         <= c_ONE << w_winner;
                        r_sticky_success <= 1'b0;
                        r_sticky_abort   <= 1'b0;
                        r_state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!i2c_busy) begin
                        i2c_activate <= 1'b1;
                        r_timer      <= '0;
                        r_state      <= S_AWAIT_START;
                    end
                end
                S_AWAIT_START: begin
                    if (i2c_busy) begin
                        i2c_activate <= 1'b0;
                        r_state      <= S_AWAIT_END;
                    end else if (r_timer == c_TO_LAST) begin
                        // Controller never started: report a self-abort.
                        i2c_activate     <= 1'b0;
                        r_sticky_abort   <= 1'b1;
                        r_sticky_success <= 1'b0;
                        req_busy         <= '0;
                        req_done         <= c_ONE << r_owner;
                        rsp_success      <= 1'b0;
                        rsp_abort        <= 1'b1;
                        rsp_data1        <= '0;
                        rsp_data2        <= '0;
                        r_state          <= S_COMPLETE;
                    end else begin
                        r_timer <= r_timer + c_TO_W'(1);
                    end
                end
                S_AWAIT_END: begin
                    r_sticky_success <= w_success_any;
                    r_sticky_abort   <= w_abort_any;
                    if (!i2c_busy) begin
                        req_busy    <= '0;
                        req_done    <= c_ONE << r_owner;
                        rsp_success <= w_success_any & ~w_abort_any;
                        rsp_abort   <= w_abort_any;
                        rsp_data1   <= i2c_data1;
                        rsp_data2   <= i2c_data2;
                        r_state     <= S_COMPLETE;
                    end
                end
                S_COMPLETE: begin
                    req_done     <= '0;
                    rsp_success  <= 1'b0;
                    rsp_abort    <= 1'b0;
                    rsp_data1    <= '0;
                    rsp_data2    <= '0;
                    r_last_grant <= r_owner;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
// ============================================================================
// Module      : tb_i2c_arbiter
// Description : Self-checking bench for i2c_arbiter with a simple controller model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_arbiter;

    localparam int N  = 2;
    localparam int RS = 6;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_activate = '0;
    logic [N-1:0]    req_read = 2'b10;
    logic [N-1:0]    req_read_two = '0;
    logic [7*N-1:0]  req_address = {7'h22, 7'h50};
    logic [8*N-1:0]  req_location = {8'h31, 8'hFD};
    logic [8*N-1:0]  req_data = {8'h42, 8'h0B};
    logic [RS*N-1:0] req_repeat = {6'd9, 6'd3};
    logic [N-1:0]    req_busy, req_done;
    logic            rsp_success, rsp_abort;
    logic [7:0]      rsp_data1, rsp_data2;
    logic            i2c_activate, i2c_read, i2c_read_two;
    logic [6:0]      i2c_address;
    logic [7:0]      i2c_location, i2c_data;
    logic [RS-1:0]   i2c_data_repeat;
    logic            i2c_busy = 1'b0, i2c_success = 1'b0, i2c_abort = 1'b0;
    logic [7:0]      i2c_data1 = '0, i2c_data2 = '0;

    int tests = 0;
    int fails = 0;

    // Controller model configuration, written by the main sequence.
    logic       cfg_ignore = 1'b0;
    int         cfg_len    = 5;
    logic       cfg_succ   = 1'b1;
    logic       cfg_abt    = 1'b0;
    logic [7:0] cfg_d1     = '0;
    logic [7:0] cfg_d2     = '0;
    int         ctrl_cnt   = 0;

    typedef struct {
        logic [N-1:0] req;
        logic         rd2;
        int           len;
        logic         succ;
        logic         abt;
        logic [7:0]   d1;
        logic [7:0]   d2;
        int           owner;
    } vec_t;

    vec_t vecs[6];

    i2c_arbiter #(
        .NUM_REQ       (N),
        .REPEAT_SZ     (RS),
        .START_TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_activate    (req_activate),
        .req_read        (req_read),
        .req_read_two    (req_read_two),
        .req_address     (req_address),
        .req_location    (req_location),
        .req_data        (req_data),
        .req_repeat      (req_repeat),
        .req_busy        (req_busy),
        .req_done        (req_done),
        .rsp_success     (rsp_success),
        .rsp_abort       (rsp_abort),
        .rsp_data1       (rsp_data1),
        .rsp_data2       (rsp_data2),
        .i2c_activate    (i2c_activate),
        .i2c_read        (i2c_read),
        .i2c_read_two    (i2c_read_two),
        .i2c_address     (i2c_address),
        .i2c_location    (i2c_location),
        .i2c_data        (i2c_data),
        .i2c_data_repeat (i2c_data_repeat),
        .i2c_busy        (i2c_busy),
        .i2c_success     (i2c_success),
        .i2c_abort       (i2c_abort),
        .i2c_data1       (i2c_data1),
        .i2c_data2       (i2c_data2)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] onehot(input int o);
        logic [N-1:0] v;
        v    = '0;
        v[o] = 1'b1;
        return v;
    endfunction

    function automatic logic [6:0] addr_of(input int o);
        return (o == 0) ? 7'h50 : 7'h22;
    endfunction
    function automatic logic [7:0] loc_of(input int o);
        return (o == 0) ? 8'hFD : 8'h31;
    endfunction
    function automatic logic [7:0] dat_of(input int o);
        return (o == 0) ? 8'h0B : 8'h42;
    endfunction
    function automatic logic [RS-1:0] rep_of(input int o);
        return (o == 0) ? 6'd3 : 6'd9;
    endfunction

    // Next requester after 'last', walking upward and wrapping.
    function automatic int rr_model(input int last, input logic [N-1:0] pat);
        for (int k = 1; k <= N; k++) begin
            if (pat[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural controller: busy for cfg_len cycles, result pulse in the first busy cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                ctrl_cnt    = 0;
                i2c_busy    = 1'b0;
                i2c_success = 1'b0;
                i2c_abort   = 1'b0;
            end else if (ctrl_cnt == 0) begin
                i2c_success = 1'b0;
                i2c_abort   = 1'b0;
                if (i2c_activate && !cfg_ignore) begin
                    i2c_busy = 1'b1;
                    ctrl_cnt = cfg_len;
                end
            end else begin
                ctrl_cnt--;
                i2c_success = (ctrl_cnt == cfg_len - 1) && cfg_succ;
                i2c_abort   = (ctrl_cnt == cfg_len - 1) && cfg_abt;
                if (ctrl_cnt == 0) begin
                    i2c_busy  = 1'b0;
                    i2c_data1 = cfg_d1;
                    i2c_data2 = cfg_d2;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            tests++;
            if ($countones(req_busy) > 1 || $countones(req_done) > 1) begin
                fails++;
                $display("FAIL onehot: busy=%b done=%b, at most one bit each required", req_busy, req_done);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_txn(input logic [N-1:0] req, input logic rd2, input int len,
                           input logic succ, input logic abt, input logic [7:0] d1,
                           input logic [7:0] d2, input int owner);
        logic exp_s, exp_a;
        bit   seen;
        exp_a = abt;
        exp_s = succ && !abt;
        @(negedge clk);
        cfg_len = len; cfg_succ = succ; cfg_abt = abt; cfg_d1 = d1; cfg_d2 = d2;
        req_read_two = {N{rd2}};
        req_activate = req;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (req_busy != '0) seen = 1;
            else @(negedge clk);
        end
        check("grant_busy", req_busy, onehot(owner));
        @(negedge clk);
        check("issue_activate", i2c_activate, 1);
        check("issue_fields",
              {i2c_address, i2c_location, i2c_data, i2c_data_repeat, i2c_read, i2c_read_two},
              {addr_of(owner), loc_of(owner), dat_of(owner), rep_of(owner), (owner == 1), rd2});
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (req_done != '0) seen = 1;
            else @(negedge clk);
        end
        check("done_owner", req_done, onehot(owner));
        check("rsp_flags", {rsp_success, rsp_abort}, {exp_s, exp_a});
        check("rsp_data", {rsp_data1, rsp_data2}, {d1, d2});
        check("busy_cleared", req_busy, 0);
        req_activate = '0;
    endtask

    initial begin
        bit   seen;
        int   cyc;
        int   last;
        int   exp;
        logic [N-1:0] pat;
        logic s, a;

        vecs[0] = '{2'b01, 1'b0, 40, 1'b1, 1'b0, 8'h00, 8'h00, 0};
        vecs[1] = '{2'b11, 1'b1,  6, 1'b1, 1'b0, 8'h11, 8'h22, 1};
        vecs[2] = '{2'b11, 1'b0,  5, 1'b0, 1'b1, 8'h33, 8'h44, 0};
        vecs[3] = '{2'b10, 1'b0,  8, 1'b1, 1'b1, 8'h55, 8'h66, 1};
        vecs[4] = '{2'b10, 1'b0,  4, 1'b1, 1'b0, 8'h77, 8'h88, 1};
        vecs[5] = '{2'b01, 1'b1,  7, 1'b1, 1'b0, 8'hA5, 8'h5A, 0};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {req_busy, req_done, rsp_success, rsp_abort, rsp_data1, rsp_data2, i2c_activate,
               i2c_read, i2c_read_two, i2c_address, i2c_location, i2c_data, i2c_data_repeat}, 0);
        reset = 1'b1;

        foreach (vecs[i])
            run_txn(vecs[i].req, vecs[i].rd2, vecs[i].len, vecs[i].succ, vecs[i].abt,
                    vecs[i].d1, vecs[i].d2, vecs[i].owner);

        // Controller never starts: self-abort after the start timeout.
        @(negedge clk);
        cfg_ignore   = 1'b1;
        req_activate = 2'b01;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (i2c_activate) seen = 1;
            else @(negedge clk);
        end
        check("timeout_activate_seen", seen, 1);
        req_activate = '0;
        cyc = 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (req_done != '0) seen = 1;
        end
        check("timeout_latency", cyc, TO);
        check("timeout_result", {req_done, rsp_abort, rsp_success, i2c_activate}, {2'b01, 1'b1, 1'b0, 1'b0});
        cfg_ignore = 1'b0;

        // Reset in the middle of a long controller transaction.
        @(negedge clk);
        cfg_len      = 30;
        req_activate = 2'b10;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (i2c_activate) seen = 1;
            else @(negedge clk);
        end
        req_activate = '0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_outputs",
              {req_busy, req_done, rsp_success, rsp_abort, rsp_data1, rsp_data2, i2c_activate,
               i2c_read, i2c_read_two, i2c_address, i2c_location, i2c_data, i2c_data_repeat}, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (req_done != '0) seen = 1;
        end
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (req_done != '0) seen = 1;
        end
        check("midreset_no_done", seen, 0);
        run_txn(2'b11, 1'b0, 5, 1'b1, 1'b0, 8'h12, 8'h34, 0);

        // Both requesters held from reset: strict alternation.
        @(negedge clk);
        reset        = 1'b0;
        req_activate = 2'b11;
        cfg_len      = 5;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                if (req_done != '0) seen = 1;
                else @(negedge clk);
            end
            check("contention_order", req_done, onehot(k % 2));
            if (k == 3) req_activate = '0;
            @(negedge clk);
        end

        // Randomised traffic against the round-robin model.
        last = 1;
        for (int t = 0; t < 20; t++) begin
            pat = N'($urandom_range(1, 3));
            exp = rr_model(last, pat);
            s   = 1'($urandom_range(0, 1));
            a   = 1'($urandom_range(0, 1));
            run_txn(pat, 1'($urandom_range(0, 1)), int'($urandom_range(3, 12)), s, a,
                    8'($urandom), 8'($urandom), exp);
            last = exp;
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
